sim_run_ctrl: RTL and testbench
===============================

# sim_run_ctrl

Parametrised run controller for the single-cycle MIPS CPU simulation harness. It sits between the top-level clock/reset and the `mips` core. It sequences the core's reset for a configurable number of cycles and counts run cycles and architectural write events. It detects program end as a self-loop with no writes, or a watchdog timeout, so benches and FPGA wrappers stop deterministically instead of relying on a fixed simulation length.

## Interface
Parameters:
- `PC_WIDTH`, 32, width of the monitored PC.
- `CNT_WIDTH`, 32, width of the cycle and write counters.
- `RST_CYCLES`, 2, number of cycles `cpu_reset` stays asserted after `reset` releases. Must be ≥1.
- `HALT_REPEAT`, 4, consecutive qualifying idle samples that declare halt. Must be ≥1.
- `MAX_CYCLES`, 100000, watchdog limit in RUN cycles. Must be ≥1 and < 2^CNT_WIDTH.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `reset`  in  1  synchronous, active-low; `reset`==0 at a rising edge resets the block.
- `pc`  in  PC_WIDTH  current PC of the core.
- `grf_we`  in  1  register-file write enable of the core.
- `dm_we`  in  1  data-memory write enable of the core.
- `cpu_reset`  out  1  active-high synchronous reset driven to the core.
- `running`  out  1  high while in RUN.
- `cycle_cnt`  out  CNT_WIDTH  number of RUN cycles elapsed.
- `wr_cnt`  out  CNT_WIDTH  RUN cycles with `grf_we|dm_we`.
- `halted`  out  1  sticky; program ended by self-loop.
- `timeout`  out  1  sticky; watchdog expired.
- `done`  out  1  `halted|timeout`.

## Operation
- The FSM has four states: RST, RUN, HALT, TOUT. All outputs are registered.
- Reset (`reset`==0) sets the following values:
  - state=RST, `rst_cnt`=0, `cpu_reset`=1, `running`=0.
  - `cycle_cnt`=0, `wr_cnt`=0, `same_cnt`=0, `pc_valid`=0, `pc_q`=0.
  - `halted`=0, `timeout`=0, `done`=0.
- RST state:
  - `rst_cnt` increments each cycle.
  - When `rst_cnt`==RST_CYCLES-1, the next state is RUN. On that same edge `cpu_reset`←0 and `running`←1.
- RUN state, on each cycle:
  - `cycle_cnt`+1.
  - `wr_cnt`+1 if `grf_we|dm_we`.
  - `pc_q`←`pc`, `pc_valid`←1.
- Idle sample: `pc_valid` && `pc`==`pc_q` && !`grf_we` && !`dm_we`.
  - An idle sample increments `same_cnt` (saturating at HALT_REPEAT).
  - Any other sample clears `same_cnt` to 0.
- Transitions out of RUN:
  - Idle sample while `same_cnt`==HALT_REPEAT-1 → HALT: `halted`←1, `done`←1.
  - Otherwise, if `cycle_cnt`==MAX_CYCLES-1 → TOUT: `timeout`←1, `done`←1.
  - If both conditions hold in the same cycle, HALT wins. `timeout` stays 0.
- HALT and TOUT are terminal until `reset`==0.
  - Counters, `pc_q` and flags freeze.
  - `running`←0. `cpu_reset` stays 0 so core state remains inspectable.
- Counter arithmetic is unsigned modulo 2^CNT_WIDTH. Overflow is impossible by the MAX_CYCLES constraint.

## Timing
- After the first edge with `reset`==1, `cpu_reset` is high for exactly RST_CYCLES further edges. With the defaults, the first edge with `reset`==1 is edge 0 and `cpu_reset` falls after edge 1.
- `cycle_cnt` reads k after the k-th RUN edge.
- The first RUN cycle never counts as idle, because `pc_valid` is 0.
- Halt latency: a loop whose PC repeats from RUN cycle j sets `halted` after edge j+HALT_REPEAT-1. For example, a PC first seen at cycle j-1 and repeating through cycle j+HALT_REPEAT-1 gives HALT_REPEAT idle samples.
- Reset mid-RUN or in a terminal state returns to RST on the next edge. All outputs revert to their reset values, and `cpu_reset` reasserts immediately.
- `reset` held low indefinitely keeps `cpu_reset`=1 and `done`=0.

## Test plan
- **Reset sequencing:** RST_CYCLES=3; release `reset` at edge 0 → `cpu_reset`=1 through edge 2, 0 after edge 2; `running`=1 from the same edge; `cycle_cnt`=0.
- **Normal halt:** PC steps 0x3000, 0x3004, 0x3008, then sticks at 0x3008 with writes off. HALT_REPEAT=4 → `halted`=1, `done`=1 after the 4th idle sample; `timeout`=0; counters freeze.
- **Write breaks idle:** PC constant 0x3010 with `grf_we` pulsing every 3rd cycle, HALT_REPEAT=4 → never halts; `wr_cnt` increments on each pulse.
- **Watchdog:** MAX_CYCLES=50, PC incrementing by 4 every cycle → `timeout`=1 after RUN edge 50, `cycle_cnt`=50, `halted`=0.
- **Simultaneous:** MAX_CYCLES=10, HALT_REPEAT=2, PC constant from RUN cycle 8 → halt and timeout coincide at edge 10 → `halted`=1, `timeout`=0.
- **Reset mid-run:** `reset`=0 at RUN cycle 20 for one edge → all counters 0 and `cpu_reset`=1 next edge; the full RST sequence repeats.

Source files
------------

// File: rtl/sim_run_ctrl.sv
// Run controller for the single-cycle MIPS harness: sequences core reset, counts run/write
// cycles and stops on a self-loop halt or a watchdog timeout.
module sim_run_ctrl #(
    parameter int PC_WIDTH    = 32,
    parameter int CNT_WIDTH   = 32,
    parameter int RST_CYCLES  = 2,
    parameter int HALT_REPEAT = 4,
    parameter int MAX_CYCLES  = 100000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PC_WIDTH-1:0]  pc,
    input  logic                 grf_we,
    input  logic                 dm_we,
    output logic                 cpu_reset,
    output logic                 running,
    output logic [CNT_WIDTH-1:0] cycle_cnt,
    output logic [CNT_WIDTH-1:0] wr_cnt,
    output logic                 halted,
    output logic                 timeout,
    output logic                 done
);

    localparam int RW = (RST_CYCLES  > 1) ? $clog2(RST_CYCLES + 1)  : 1;
    localparam int SW = (HALT_REPEAT > 1) ? $clog2(HALT_REPEAT + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(MAX_CYCLES - 1);
    localparam logic [RW-1:0]        RST_LAST = RW'(RST_CYCLES - 1);
    localparam logic [SW-1:0]        SAME_MAX = SW'(HALT_REPEAT);
    localparam logic [SW-1:0]        SAME_HIT = SW'(HALT_REPEAT - 1);

    typedef enum logic [1:0] {
        ST_RST,
        ST_RUN,
        ST_HALT,
        ST_TOUT
    } state_t;

    state_t              state;
    logic [RW-1:0]       rst_cnt;
    logic [SW-1:0]       same_cnt;
    logic                pc_valid;
    logic [PC_WIDTH-1:0] pc_q;
    logic                idle;
    logic                wr_any;

    function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
        return (v == SAME_MAX) ? v : v + SW'(1);
    endfunction

    assign wr_any = grf_we | dm_we;
    // The very first RUN sample has no previous PC to compare against, hence pc_valid.
    assign idle   = pc_valid && (pc == pc_q) && !wr_any;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_RST;
            rst_cnt   <= '0;
            cpu_reset <= 1'b1;
            running   <= 1'b0;
            cycle_cnt <= '0;
            wr_cnt    <= '0;
            same_cnt  <= '0;
            pc_valid  <= 1'b0;
            pc_q      <= '0;
            halted    <= 1'b0;
            timeout   <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_RST: begin
                    rst_cnt <= rst_cnt + RW'(1);
                    if (rst_cnt == RST_LAST) begin
                        state     <= ST_RUN;
                        cpu_reset <= 1'b0;
                        running   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    cycle_cnt <= cycle_cnt + CNT_ONE;
                    if (wr_any) wr_cnt <= wr_cnt + CNT_ONE;
                    pc_q     <= pc;
                    pc_valid <= 1'b1;
                    same_cnt <= idle ? sat_inc(same_cnt) : '0;
                    // Halt has priority over the watchdog when both fire on the same edge.
                    if (idle && (same_cnt == SAME_HIT)) begin
                        state   <= ST_HALT;
                        halted  <= 1'b1;
                        done    <= 1'b1;
                        running <= 1'b0;
                    end else if (cycle_cnt == CNT_LAST) begin
                        state   <= ST_TOUT;
                        timeout <= 1'b1;
                        done    <= 1'b1;
                        running <= 1'b0;
                    end
                end
                default: begin
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Bench for sim_run_ctrl: two differently parametrised instances share one stimulus stream
// and are compared every cycle against a history-based reference model.
module tb_sim_run_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        grf_we;
    logic        dm_we;

    logic        cpu_reset_a, running_a, halted_a, timeout_a, done_a;
    logic [31:0] cycle_cnt_a, wr_cnt_a;
    logic        cpu_reset_b, running_b, halted_b, timeout_b, done_b;
    logic [31:0] cycle_cnt_b, wr_cnt_b;

    int tests = 0;
    int fails = 0;

    // Inputs seen at every edge with reset high since the last reset-low edge.
    logic [31:0] hpc[$];
    bit          hwe[$];

    typedef struct packed {
        logic        cr;
        logic        run;
        logic        h;
        logic        t;
        logic        d;
        logic [31:0] cc;
        logic [31:0] wc;
    } exp_t;

    sim_run_ctrl #(.PC_WIDTH(32), .CNT_WIDTH(32), .RST_CYCLES(3), .HALT_REPEAT(4), .MAX_CYCLES(50)) dut_a (
        .clk(clk), .reset(reset), .pc(pc), .grf_we(grf_we), .dm_we(dm_we),
        .cpu_reset(cpu_reset_a), .running(running_a), .cycle_cnt(cycle_cnt_a), .wr_cnt(wr_cnt_a),
        .halted(halted_a), .timeout(timeout_a), .done(done_a)
    );

    sim_run_ctrl #(.PC_WIDTH(32), .CNT_WIDTH(32), .RST_CYCLES(2), .HALT_REPEAT(2), .MAX_CYCLES(10)) dut_b (
        .clk(clk), .reset(reset), .pc(pc), .grf_we(grf_we), .dm_we(dm_we),
        .cpu_reset(cpu_reset_b), .running(running_b), .cycle_cnt(cycle_cnt_b), .wr_cnt(wr_cnt_b),
        .halted(halted_b), .timeout(timeout_b), .done(done_b)
    );

    always #5 clk = ~clk;

    // Replays the recorded history: core reset for rc edges, then one RUN cycle per edge,
    // ending at the first run of hr idle samples or at run cycle mx, whichever comes first.
    function automatic exp_t model(input int rc, input int hr, input int mx);
        exp_t r;
        int   e;
        int   idle_run;
        int   idx;
        r        = '0;
        idle_run = 0;
        e        = hpc.size();
        r.cr     = (e < rc);
        for (int i = 1; i <= e - rc; i++) begin
            if (r.d) break;
            idx  = rc + i - 1;
            r.cc = 32'(i);
            if (hwe[idx]) r.wc = r.wc + 32'd1;
            if (i > 1 && hpc[idx] == hpc[idx-1] && !hwe[idx]) idle_run++;
            else idle_run = 0;
            if (idle_run >= hr) begin
                r.h = 1'b1;
                r.d = 1'b1;
            end else if (i == mx) begin
                r.t = 1'b1;
                r.d = 1'b1;
            end
        end
        r.run = (e >= rc) && !r.d;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        exp_t ea;
        exp_t eb;
        ea = model(3, 4, 50);
        eb = model(2, 2, 10);
        check("a_cpu_reset", 32'(cpu_reset_a), 32'(ea.cr));
        check("a_running",   32'(running_a),   32'(ea.run));
        check("a_halted",    32'(halted_a),    32'(ea.h));
        check("a_timeout",   32'(timeout_a),   32'(ea.t));
        check("a_done",      32'(done_a),      32'(ea.d));
        check("a_cycle_cnt", cycle_cnt_a,      ea.cc);
        check("a_wr_cnt",    wr_cnt_a,         ea.wc);
        check("b_cpu_reset", 32'(cpu_reset_b), 32'(eb.cr));
        check("b_running",   32'(running_b),   32'(eb.run));
        check("b_halted",    32'(halted_b),    32'(eb.h));
        check("b_timeout",   32'(timeout_b),   32'(eb.t));
        check("b_done",      32'(done_b),      32'(eb.d));
        check("b_cycle_cnt", cycle_cnt_b,      eb.cc);
        check("b_wr_cnt",    wr_cnt_b,         eb.wc);
    endtask

    task automatic step(input logic rst_n, input logic [31:0] p, input logic g, input logic d);
        reset  = rst_n;
        pc     = p;
        grf_we = g;
        dm_we  = d;
        @(posedge clk);
        if (!rst_n) begin
            hpc.delete();
            hwe.delete();
        end else begin
            hpc.push_back(p);
            hwe.push_back(g | d);
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        logic [31:0] p;
        reset  = 1'b0;
        pc     = '0;
        grf_we = 1'b0;
        dm_we  = 1'b0;

        // Reset held low: core stays in reset, nothing done.
        for (int t = 0; t < 6; t++) step(1'b0, 32'h3000, 1'b0, 1'b0);
        check("hold_cpu_reset", 32'(cpu_reset_a), 32'd1);

        // Normal halt: 0x3000, 0x3004, 0x3008 on the first RUN cycles of A, then stuck.
        for (int t = 0; t < 20; t++)
            step(1'b1, (t <= 5) ? 32'h2FF4 + 32'(4 * t) : 32'h3008, 1'b0, 1'b0);
        check("halt_a_halted", 32'(halted_a), 32'd1);
        check("halt_a_cycles", cycle_cnt_a, 32'd7);
        check("halt_a_timeout", 32'(timeout_a), 32'd0);

        // Write pulses every third cycle keep a constant PC from halting A.
        step(1'b0, 32'h0, 1'b0, 1'b0);
        for (int t = 0; t < 40; t++) step(1'b1, 32'h3010, (t % 3) == 2, 1'b0);
        check("wr_a_running", 32'(running_a), 32'd1);
        check("wr_a_writes", wr_cnt_a, 32'd12);

        // Watchdog on A: PC keeps moving, random write traffic.
        step(1'b0, 32'h0, 1'b0, 1'b0);
        for (int t = 0; t < 60; t++)
            step(1'b1, 32'h4000 + 32'(4 * t), ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
        check("wd_a_timeout", 32'(timeout_a), 32'd1);
        check("wd_a_cycles", cycle_cnt_a, 32'd50);

        // Halt and watchdog coincide on B at run cycle 10.
        step(1'b0, 32'h0, 1'b0, 1'b0);
        for (int t = 0; t < 15; t++)
            step(1'b1, (t < 9) ? 32'h100 + 32'(4 * t) : 32'h500, 1'b0, 1'b0);
        check("sim_b_halted", 32'(halted_b), 32'd1);
        check("sim_b_timeout", 32'(timeout_b), 32'd0);
        check("sim_b_cycles", cycle_cnt_b, 32'd10);

        // Reset at A's run cycle 20, then the full sequence again.
        step(1'b0, 32'h0, 1'b0, 1'b0);
        for (int t = 0; t < 23; t++) step(1'b1, 32'h8000 + 32'(4 * t), 1'b0, 1'b0);
        check("mid_a_cycles_before", cycle_cnt_a, 32'd20);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        check("mid_a_cpu_reset", 32'(cpu_reset_a), 32'd1);
        check("mid_a_cycles", cycle_cnt_a, 32'd0);
        for (int t = 0; t < 8; t++) step(1'b1, 32'h9000 + 32'(4 * t), 1'b0, 1'b1);

        // Random traffic: PCs that often repeat, sparse writes, occasional resets.
        p = 32'h3000;
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 3) == 0) p = 32'h3000 + 32'(4 * $urandom_range(0, 3));
            step(($urandom_range(0, 39) != 0), p, ($urandom_range(0, 9) == 0), ($urandom_range(0, 15) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
